// File: rtl/wb_retire_buf.sv
// rtl/wb_retire_buf.sv - in-order writeback retire queue with ID-stage forwarding
module wb_retire_buf #(
  parameter int DEPTH = 2,
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int PCW   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  wb_allowin,
  input  logic                  mem_to_wb_valid,
  input  logic [AW+DW+PCW:0]    mem_to_wb_bus,
  input  logic                  trace_ready,
  output logic                  rf_we,
  output logic [AW-1:0]         rf_waddr,
  output logic [DW-1:0]         rf_wdata,
  output logic [PCW-1:0]        debug_wb_pc,
  output logic [3:0]            debug_wb_rf_wen,
  output logic [AW-1:0]         debug_wb_rf_wnum,
  output logic [DW-1:0]         debug_wb_rf_wdata,
  input  logic [AW-1:0]         id_raddr1,
  input  logic [AW-1:0]         id_raddr2,
  output logic                  fwd1_hit,
  output logic [DW-1:0]         fwd1_data,
  output logic                  fwd2_hit,
  output logic [DW-1:0]         fwd2_data,
  output logic [$clog2(DEPTH):0] wb_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // Entry storage is deliberately not reset; occupancy is tracked by count_q.
  logic           ent_regw_q  [DEPTH];
  logic           ent_regw_d  [DEPTH];
  logic [AW-1:0]  ent_waddr_q [DEPTH];
  logic [AW-1:0]  ent_waddr_d [DEPTH];
  logic [DW-1:0]  ent_wdata_q [DEPTH];
  logic [DW-1:0]  ent_wdata_d [DEPTH];
  logic [PCW-1:0] ent_pc_q    [DEPTH];
  logic [PCW-1:0] ent_pc_d    [DEPTH];

  logic           in_regw;
  logic [AW-1:0]  in_waddr;
  logic [DW-1:0]  in_wdata;
  logic [PCW-1:0] in_pc;

  logic empty, full, retire, enq;
  logic [PW-1:0] fwd_idx;

  assign in_regw  = mem_to_wb_bus[AW+DW+PCW];
  assign in_waddr = mem_to_wb_bus[AW+DW+PCW-1 -: AW];
  assign in_wdata = mem_to_wb_bus[DW+PCW-1 -: DW];
  assign in_pc    = mem_to_wb_bus[PCW-1:0];

  // Handshake flags; allowin looks through a same-cycle retire so a full queue keeps streaming.
  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == CW'(DEPTH));
    retire     = ~empty & trace_ready;
    wb_allowin = ~full | retire;
    enq        = mem_to_wb_valid & wb_allowin;
  end

  // Next-state for pointers, occupancy and the entry written at tail.
  always_comb begin
    head_d  = head_q + PW'(retire);
    tail_d  = tail_q + PW'(enq);
    count_d = count_q + CW'(enq) - CW'(retire);
    for (int i = 0; i < DEPTH; i++) begin
      ent_regw_d[i]  = ent_regw_q[i];
      ent_waddr_d[i] = ent_waddr_q[i];
      ent_wdata_d[i] = ent_wdata_q[i];
      ent_pc_d[i]    = ent_pc_q[i];
    end
    if (enq) begin
      ent_regw_d[tail_q]  = in_regw;
      ent_waddr_d[tail_q] = in_waddr;
      ent_wdata_d[tail_q] = in_wdata;
      ent_pc_d[tail_q]    = in_pc;
    end
  end

  // Pointer and occupancy registers; reset drops every pending entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload registers.
  always_ff @(posedge clk) begin
    ent_regw_q  <= ent_regw_d;
    ent_waddr_q <= ent_waddr_d;
    ent_wdata_q <= ent_wdata_d;
    ent_pc_q    <= ent_pc_d;
  end

  // Head entry drives regfile and trace; head fields are shown even while stalled.
  always_comb begin
    rf_we             = retire & ent_regw_q[head_q];
    rf_waddr          = empty ? '0 : ent_waddr_q[head_q];
    rf_wdata          = empty ? '0 : ent_wdata_q[head_q];
    debug_wb_pc       = empty ? '0 : ent_pc_q[head_q];
    debug_wb_rf_wen   = {4{rf_we}};
    debug_wb_rf_wnum  = rf_waddr;
    debug_wb_rf_wdata = rf_wdata;
    wb_count          = count_q;
  end

  // Forwarding search walks oldest to youngest so the youngest match is left standing.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    fwd_idx   = '0;
    for (int a = 0; a < DEPTH; a++) begin
      fwd_idx = head_q + PW'(a);
      if ((CW'(a) < count_q) && ent_regw_q[fwd_idx]) begin
        if ((id_raddr1 != '0) && (ent_waddr_q[fwd_idx] == id_raddr1)) begin
          fwd1_hit  = 1'b1;
          fwd1_data = ent_wdata_q[fwd_idx];
        end
        if ((id_raddr2 != '0) && (ent_waddr_q[fwd_idx] == id_raddr2)) begin
          fwd2_hit  = 1'b1;
          fwd2_data = ent_wdata_q[fwd_idx];
        end
      end
    end
  end

  // Enqueue into a full queue without a retire would overwrite the head.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(enq && full && !retire));
    end
  end

endmodule

// File: tb/tb_wb_retire_buf.sv
// tb/tb_wb_retire_buf.sv - randomized and directed bench for wb_retire_buf against a queue model
module tb_wb_retire_buf;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int PCW   = 32;
  localparam int BW    = 1 + AW + DW + PCW;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           wb_allowin;
  logic           mem_to_wb_valid;
  logic [BW-1:0]  mem_to_wb_bus;
  logic           trace_ready;
  logic           rf_we;
  logic [AW-1:0]  rf_waddr;
  logic [DW-1:0]  rf_wdata;
  logic [PCW-1:0] debug_wb_pc;
  logic [3:0]     debug_wb_rf_wen;
  logic [AW-1:0]  debug_wb_rf_wnum;
  logic [DW-1:0]  debug_wb_rf_wdata;
  logic [AW-1:0]  id_raddr1;
  logic [AW-1:0]  id_raddr2;
  logic           fwd1_hit;
  logic [DW-1:0]  fwd1_data;
  logic           fwd2_hit;
  logic [DW-1:0]  fwd2_data;
  logic [CW-1:0]  wb_count;

  always #5 clk = ~clk;

  wb_retire_buf #(.DEPTH(DEPTH), .DW(DW), .AW(AW), .PCW(PCW)) dut (
    .clk(clk), .reset(reset), .wb_allowin(wb_allowin),
    .mem_to_wb_valid(mem_to_wb_valid), .mem_to_wb_bus(mem_to_wb_bus),
    .trace_ready(trace_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .id_raddr1(id_raddr1), .id_raddr2(id_raddr2),
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data), .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
    .wb_count(wb_count)
  );

  typedef struct {
    logic           regw;
    logic [AW-1:0]  waddr;
    logic [DW-1:0]  wdata;
    logic [PCW-1:0] pc;
  } ent_t;

  ent_t mq[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc_no = 0;

  function automatic logic [BW-1:0] mk(input logic regw, input logic [AW-1:0] wa,
                                       input logic [DW-1:0] wd, input logic [PCW-1:0] pc);
    return {regw, wa, wd, pc};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s @cyc%0d: observed=%0h expected=%0h", tag, cyc_no, obs, exp_v);
    end
  endtask

  function automatic void lookup(input logic [AW-1:0] ra, output logic hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (ra != '0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].regw && mq[i].waddr == ra) begin
          hit = 1'b1;
          d   = mq[i].wdata;
          break;
        end
      end
    end
  endfunction

  // Compare every output against the queue model for the current inputs.
  task automatic check_all();
    int             n;
    logic           ret, e_we, h1, h2;
    logic [AW-1:0]  e_wa;
    logic [DW-1:0]  e_wd, d1, d2;
    logic [PCW-1:0] e_pc;
    n    = mq.size();
    ret  = (n > 0) && trace_ready;
    e_we = ret && mq[0].regw;
    e_wa = (n > 0) ? mq[0].waddr : '0;
    e_wd = (n > 0) ? mq[0].wdata : '0;
    e_pc = (n > 0) ? mq[0].pc    : '0;
    lookup(id_raddr1, h1, d1);
    lookup(id_raddr2, h2, d2);
    chk("wb_count",   64'(wb_count), 64'(n));
    chk("wb_allowin", 64'(wb_allowin), 64'((n < DEPTH) || ret));
    chk("rf_we",      64'(rf_we), 64'(e_we));
    chk("rf_waddr",   64'(rf_waddr), 64'(e_wa));
    chk("rf_wdata",   64'(rf_wdata), 64'(e_wd));
    chk("debug_pc",   64'(debug_wb_pc), 64'(e_pc));
    chk("debug_wen",  64'(debug_wb_rf_wen), e_we ? 64'hf : 64'h0);
    chk("debug_wnum", 64'(debug_wb_rf_wnum), 64'(e_wa));
    chk("debug_wdat", 64'(debug_wb_rf_wdata), 64'(e_wd));
    chk("fwd1_hit",   64'(fwd1_hit), 64'(h1));
    chk("fwd1_data",  64'(fwd1_data), 64'(d1));
    chk("fwd2_hit",   64'(fwd2_hit), 64'(h2));
    chk("fwd2_data",  64'(fwd2_data), 64'(d2));
  endtask

  // One clock: drive at negedge, check before the rising edge, then advance the model.
  // Returns whether the model accepted the presented entry.
  task automatic cyc(input logic v, input logic [BW-1:0] b, input logic tr,
                     input logic [AW-1:0] r1, input logic [AW-1:0] r2, output logic acc);
    int   n;
    logic ret;
    ent_t e;
    @(negedge clk);
    cyc_no++;
    mem_to_wb_valid = v;
    mem_to_wb_bus   = b;
    trace_ready     = tr;
    id_raddr1       = r1;
    id_raddr2       = r2;
    #1;
    check_all();
    n   = mq.size();
    ret = (n > 0) && tr;
    acc = v && ((n < DEPTH) || ret);
    if (ret) void'(mq.pop_front());
    if (acc) begin
      {e.regw, e.waddr, e.wdata, e.pc} = b;
      mq.push_back(e);
    end
  endtask

  task automatic drain();
    logic a;
    int   guard = 0;
    while (mq.size() > 0 && guard < 64) begin
      cyc(1'b0, '0, 1'b1, 5'd0, 5'd0, a);
      guard++;
    end
    cyc(1'b0, '0, 1'b1, 5'd0, 5'd0, a);
    chk("drain_empty", 64'(wb_count), 64'd0);
  endtask

  initial begin
    logic            a;
    logic [BW-1:0]   pend;
    int              sent;
    int              k;
    reset           = 1'b1;
    mem_to_wb_valid = 1'b0;
    mem_to_wb_bus   = '0;
    trace_ready     = 1'b1;
    id_raddr1       = 5'd3;
    id_raddr2       = 5'd7;
    repeat (2) @(negedge clk);
    #1;
    check_all();
    chk("rst_allowin", 64'(wb_allowin), 64'd1);
    reset = 1'b0;

    // Single entry: retires the cycle after enqueue, then queue is empty.
    cyc(1'b1, mk(1'b1, 5'd3, 32'h1111_0001, 32'h1c00_0000), 1'b1, 5'd3, 5'd0, a);
    cyc(1'b0, '0, 1'b1, 5'd3, 5'd0, a);
    chk("t1_we",    64'(rf_we), 64'd1);
    chk("t1_waddr", 64'(rf_waddr), 64'd3);
    chk("t1_wdata", 64'(rf_wdata), 64'h1111_0001);
    chk("t1_pc",    64'(debug_wb_pc), 64'h1c00_0000);
    chk("t1_wen",   64'(debug_wb_rf_wen), 64'hf);
    chk("t1_fwd_retiring", 64'(fwd1_hit), 64'd1);
    cyc(1'b0, '0, 1'b1, 5'd0, 5'd0, a);
    chk("t1_count", 64'(wb_count), 64'd0);

    // Fill with trace stalled, then release with MEM still holding its bus.
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b1, mk(1'b1, 5'(10 + i), 32'hA000_0000 + i, 32'h1c00_0100 + 4 * i), 1'b0, 5'd0, 5'd0, a);
    pend = mk(1'b1, 5'd20, 32'hBEEF_0000, 32'h1c00_0200);
    cyc(1'b1, pend, 1'b0, 5'd0, 5'd0, a);
    chk("t2_full_allowin", 64'(wb_allowin), 64'd0);
    chk("t2_full_count",   64'(wb_count), 64'(DEPTH));
    chk("t2_stall_we",     64'(rf_we), 64'd0);
    cyc(1'b1, pend, 1'b1, 5'd0, 5'd0, a);
    chk("t2_release_allowin", 64'(wb_allowin), 64'd1);
    cyc(1'b0, '0, 1'b0, 5'd0, 5'd0, a);
    chk("t2_count_kept", 64'(wb_count), 64'(DEPTH));
    drain();

    // Forwarding: youngest of two r7 writes wins; r0 never forwards.
    cyc(1'b1, mk(1'b1, 5'd7, 32'h0000_000A, 32'h1c00_0300), 1'b0, 5'd0, 5'd0, a);
    cyc(1'b1, mk(1'b1, 5'd9, 32'h0000_000B, 32'h1c00_0304), 1'b0, 5'd0, 5'd0, a);
    cyc(1'b1, mk(1'b1, 5'd7, 32'h0000_000C, 32'h1c00_0308), 1'b0, 5'd0, 5'd0, a);
    cyc(1'b1, mk(1'b1, 5'd0, 32'h0000_000D, 32'h1c00_030c), 1'b0, 5'd0, 5'd0, a);
    cyc(1'b0, '0, 1'b0, 5'd7, 5'd0, a);
    chk("t3_fwd1_hit",  64'(fwd1_hit), 64'd1);
    chk("t3_fwd1_data", 64'(fwd1_data), 64'h0000_000C);
    chk("t3_fwd2_r0",   64'(fwd2_hit), 64'd0);
    cyc(1'b0, '0, 1'b0, 5'd9, 5'd7, a);
    chk("t3_fwd1_r9",   64'(fwd1_data), 64'h0000_000B);
    drain();

    // Store (regW=0) is traced but neither writes nor forwards.
    cyc(1'b1, mk(1'b0, 5'd12, 32'h5555_5555, 32'h1c00_0400), 1'b0, 5'd12, 5'd0, a);
    cyc(1'b0, '0, 1'b0, 5'd12, 5'd12, a);
    chk("t5_no_fwd", 64'(fwd1_hit), 64'd0);
    cyc(1'b0, '0, 1'b1, 5'd12, 5'd0, a);
    chk("t5_we",  64'(rf_we), 64'd0);
    chk("t5_wen", 64'(debug_wb_rf_wen), 64'd0);
    chk("t5_pc",  64'(debug_wb_pc), 64'h1c00_0400);
    drain();

    // Wrap: 10 back-to-back entries with trace_ready toggling.
    sent = 0;
    k    = 0;
    pend = mk(1'b1, 5'd1, 32'hC000_0000, 32'h1c00_1000);
    while (sent < 10 && k < 100) begin
      cyc(1'b1, pend, (k % 2) == 0, 5'(k % 4), 5'd1, a);
      if (a) begin
        sent++;
        pend = mk(1'b1, 5'(1 + sent % 3), 32'hC000_0000 + sent, 32'h1c00_1000 + 4 * sent);
      end
      k++;
    end
    chk("t4_all_sent", 64'(sent), 64'd10);
    drain();

    // Asynchronous reset with pending entries.
    cyc(1'b1, mk(1'b1, 5'd4, 32'hDEAD_0001, 32'h1c00_2000), 1'b0, 5'd4, 5'd0, a);
    cyc(1'b1, mk(1'b1, 5'd5, 32'hDEAD_0002, 32'h1c00_2004), 1'b0, 5'd4, 5'd5, a);
    @(negedge clk);
    mem_to_wb_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    mq.delete();
    chk("t6_count",   64'(wb_count), 64'd0);
    chk("t6_allowin", 64'(wb_allowin), 64'd1);
    chk("t6_fwd1",    64'(fwd1_hit), 64'd0);
    chk("t6_fwd2",    64'(fwd2_hit), 64'd0);
    chk("t6_we",      64'(rf_we), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 5'd4, 5'd5, a);

    // Random traffic; MEM holds an entry until it is accepted.
    pend = mk(1'($urandom_range(1)), 5'($urandom_range(7)), $urandom, $urandom);
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(1)), pend, 1'($urandom_range(1)),
          5'($urandom_range(7)), 5'($urandom_range(7)), a);
      if (a) pend = mk(1'($urandom_range(1)), 5'($urandom_range(7)), $urandom, $urandom);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
